ram_fifo_controller: RTL

//  Valid/ready FIFO controller that drives an external DualPortRam: port A is the write port, port B the read port.

---
 rtl/ram_fifo_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ram_fifo_controller.sv
// ram_fifo_controller
//   Valid/ready FIFO controller in front of an external dual-port RAM.
//   Port A of the RAM is the write port and port B is the read port.
//   The RAM read data arrives one cycle after the address is presented.
//   The controller owns:
//     - the write and read pointers, each with a wrap bit
//     - the full and empty decisions
//     - a 2-entry output buffer that hides the RAM read latency
//   Capacity is 2^ADDR_WIDTH RAM words plus the 2 buffer words.
//
// Ports
//   Clk, ResetN           clock; synchronous active-low reset
//   InValid/InReady/InData     producer handshake and data
//   OutValid/OutReady/OutData  consumer handshake and data (registered)
//   Level                 words held: RAM + in-flight read + buffer
//   RamWriteA/RamAddrA/RamInputA  RAM write port
//   RamAddrB/RamOutputB   RAM read port (data registered inside the RAM)

module ram_fifo_controller #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DATA_WIDTH-1:0] InData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic [ADDR_WIDTH+1:0] Level,
    output logic                  RamWriteA,
    output logic [ADDR_WIDTH-1:0] RamAddrA,
    output logic [DATA_WIDTH-1:0] RamInputA,
    output logic [ADDR_WIDTH-1:0] RamAddrB,
    input  logic [DATA_WIDTH-1:0] RamOutputB
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int LW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Registered state
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  in_flight_q, in_flight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];

    // Combinational helpers
    logic [PW-1:0] ram_used;
    logic          ram_full;
    logic          ram_empty;
    logic          push;
    logic          pop;
    logic          issue;
    logic [2:0]    occ_after_pop;
    logic [1:0]    cnt_after_pop;

    // Pointer distance modulo 2^(ADDR_WIDTH+1).
    // The wrap bit keeps full and empty distinct.
    assign ram_used  = wr_ptr_q - rd_ptr_q;
    assign ram_full  = (ram_used == DEPTH_P);
    assign ram_empty = (ram_used == '0);

    // Write side.
    // InReady is held low during reset, so no RAM write can happen then.
    assign InReady   = ResetN & ~ram_full;
    assign push      = InValid & InReady;
    assign RamWriteA = push;
    assign RamAddrA  = wr_ptr_q[ADDR_WIDTH-1:0];
    assign RamInputA = InData;

    // Output side
    assign OutValid = (buf_cnt_q != 2'd0);
    assign OutData  = buf_q[0];
    assign pop      = OutValid & OutReady;

    // A read is issued only if its word is guaranteed a buffer slot.
    // The slot count includes the word already in flight.
    // It also credits the slot freed by a pop in this same cycle.
    // Crediting the pop gives back-to-back throughput.
    // It also lets a pop at full re-open InReady on the very next cycle.
    assign occ_after_pop = {1'b0, buf_cnt_q} + {2'b0, in_flight_q} - {2'b0, pop};
    assign issue         = ResetN & ~ram_empty & (occ_after_pop < 3'd2);
    assign RamAddrB      = rd_ptr_q[ADDR_WIDTH-1:0];

    // A pop can never happen with an empty buffer.
    // So this subtraction does not underflow.
    assign cnt_after_pop = buf_cnt_q - {1'b0, pop};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        in_flight_d = issue;
        buf_cnt_d   = cnt_after_pop;
        buf_d[0]    = buf_q[0];
        buf_d[1]    = buf_q[1];

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Pop shifts the tail into the head.
        if (pop) begin
            buf_d[0] = buf_q[1];
        end

        // The returning RAM word goes into the first free slot after the pop.
        // The issue rule guarantees cnt_after_pop is 0 or 1 here.
        if (in_flight_q) begin
            buf_d[cnt_after_pop[0]] = RamOutputB;
            buf_cnt_d               = cnt_after_pop + 2'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_flight_q <= 1'b0;
            buf_cnt_q   <= 2'd0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_flight_q <= in_flight_d;
            buf_cnt_q   <= buf_cnt_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
        end
    end

    // Level is derived from registered state only.
    // So it reflects a push or pop on the following edge.
    assign Level = LW'(ram_used) + LW'(in_flight_q) + LW'(buf_cnt_q);

endmodule
